// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment driver: accepts a binary value by valid/ready,
// converts it to BCD with a serial double-dabble and scans it out with blanking.
module seg7_scan_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic [3:0]  dp_en,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int DW = $clog2(REFRESH_DIV + 1);
  localparam logic [DW-1:0] DIV_MAX   = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYCLES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]  state;
  logic [13:0] shift_bin;
  logic [15:0] shift_bcd;
  logic [3:0]  shift_cnt;
  logic [3:0]  dp_lat;
  logic        ovf_lat;
  logic [15:0] disp_bcd;
  logic [3:0]  disp_dp;
  logic        disp_ovf;

  logic [15:0] bcd_adj;
  logic [15:0] bcd_next;
  logic [13:0] bin_next;

  // Double-dabble step: add 3 to every nibble >= 5, then shift the whole pair left.
  always_comb begin
    bcd_adj = shift_bcd;
    for (int i = 0; i < 4; i++) begin
      if (shift_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = shift_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign {bcd_next, bin_next} = {bcd_adj[14:0], shift_bin, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      value_ready <= 1'b0;
      shift_bin   <= '0;
      shift_bcd   <= '0;
      shift_cnt   <= '0;
      dp_lat      <= '0;
      ovf_lat     <= 1'b0;
      disp_bcd    <= '0;
      disp_dp     <= '0;
      disp_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          value_ready <= 1'b1;
          if (value_valid && value_ready) begin
            shift_bin   <= value;
            shift_bcd   <= '0;
            shift_cnt   <= '0;
            dp_lat      <= dp_en;
            ovf_lat     <= (value > 14'd9999);
            value_ready <= 1'b0;
            state       <= ST_SHIFT;
          end
        end
        default: begin
          shift_bcd <= bcd_next;
          shift_bin <= bin_next;
          shift_cnt <= shift_cnt + 4'd1;
          // Last shift: commit digits, dp and overflow together so the display never tears.
          if (shift_cnt == 4'd13) begin
            disp_bcd    <= bcd_next;
            disp_dp     <= dp_lat;
            disp_ovf    <= ovf_lat;
            value_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'h3F;
      4'd1:    seg_encode = 7'h06;
      4'd2:    seg_encode = 7'h5B;
      4'd3:    seg_encode = 7'h4F;
      4'd4:    seg_encode = 7'h66;
      4'd5:    seg_encode = 7'h6D;
      4'd6:    seg_encode = 7'h7D;
      4'd7:    seg_encode = 7'h07;
      4'd8:    seg_encode = 7'h7F;
      4'd9:    seg_encode = 7'h6F;
      default: seg_encode = 7'h00;
    endcase
  endfunction

  logic [DW-1:0] div;
  logic [1:0]    slot;
  logic [3:0]    lz_blank;
  logic [3:0]    cur_digit;
  logic [6:0]    pat;
  logic          dp_on;
  logic [3:0]    an_on;

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (disp_bcd[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (disp_bcd[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (disp_bcd[7:4] == 4'd0);
  end

  always_comb begin
    cur_digit = disp_bcd[{slot, 2'b00} +: 4];
    pat       = disp_ovf ? 7'h40 : (lz_blank[slot] ? 7'h00 : seg_encode(cur_digit));
    dp_on     = disp_dp[slot];
    an_on     = 4'b0001 << slot;
    if (div < BLANK_END) begin
      pat   = 7'h00;
      dp_on = 1'b0;
      an_on = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      slot <= 2'd0;
      an   <= {4{AN_ACT_LOW}};
      seg  <= {7{SEG_ACT_LOW}};
      dp   <= SEG_ACT_LOW;
    end else begin
      an  <= an_on ^ {4{AN_ACT_LOW}};
      seg <= pat ^ {7{SEG_ACT_LOW}};
      dp  <= dp_on ^ SEG_ACT_LOW;
      if (div == DIV_MAX) begin
        div  <= '0;
        slot <= slot + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with a short refresh period (8 cycles, 2 blank).
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic [3:0]  dp_en;
  logic        value_valid;
  logic        value_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  // Expected pin patterns (active-low), packed {digit3, digit2, digit1, digit0}.
  localparam logic [27:0] SEG_ZERO  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] SEG_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] SEG_7     = {7'h7F, 7'h7F, 7'h7F, 7'h78};
  localparam logic [27:0] SEG_9999  = {7'h10, 7'h10, 7'h10, 7'h10};
  localparam logic [27:0] SEG_DASH  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [27:0] SEG_42    = {7'h7F, 7'h7F, 7'h19, 7'h24};
  localparam logic [27:0] SEG_5678  = {7'h12, 7'h02, 7'h78, 7'h00};

  seg7_scan_display #(
    .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp_en(dp_en), .value_valid(value_valid),
    .value_ready(value_ready), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // Independent scan model: divider/slot as seen one cycle late on the pins.
  int  mdiv = 0, mslot = 0, pdiv = 0, pslot = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mdiv <= 0; mslot <= 0; pdiv <= 0; pslot <= 0; mon_en <= 1'b1;
    end else begin
      pdiv  <= mdiv;
      pslot <= mslot;
      if (mdiv == 7) begin
        mdiv  <= 0;
        mslot <= (mslot + 1) % 4;
      end else begin
        mdiv <= mdiv + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("[TB] FAIL onehot: an=%b has more than one active anode", an);
      end
      checks++;
      if (pdiv < 2) begin
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
          errors++;
          $display("[TB] FAIL blank: div=%0d an=%h seg=%h dp=%b, required an=F seg=7F dp=1",
                   pdiv, an, seg, dp);
        end
      end else if (an !== ~(4'b0001 << pslot)) begin
        errors++;
        $display("[TB] FAIL scan_slot: an=%b, required %b", an, ~(4'b0001 << pslot));
      end
    end
  end

  task automatic check_digits(input logic [27:0] exp_seg, input logic [3:0] exp_dp,
                              input string name);
    for (int k = 0; k < 4; k++) begin
      int  waited = 0;
      while (an !== ~(4'b0001 << k) && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (waited >= 40) begin
        errors++;
        $display("[TB] FAIL %s_d%0d: anode never activated (an=%b)", name, k, an);
      end else if (seg !== exp_seg[7*k +: 7] || dp !== exp_dp[k]) begin
        errors++;
        $display("[TB] FAIL %s_d%0d: seg=%h dp=%b, required seg=%h dp=%b",
                 name, k, seg, dp, exp_seg[7*k +: 7], exp_dp[k]);
      end
    end
  endtask

  // One sample of whatever digit is currently lit against an expected display.
  task automatic check_active(input logic [27:0] exp_seg, input logic [3:0] exp_dp,
                              input string name);
    if (an !== 4'hF) begin
      int j = 0;
      for (int b = 3; b >= 0; b--) if (an[b] == 1'b0) j = b;
      checks++;
      if (seg !== exp_seg[7*j +: 7] || dp !== exp_dp[j]) begin
        errors++;
        $display("[TB] FAIL %s_hold_d%0d: seg=%h dp=%b, required seg=%h dp=%b",
                 name, j, seg, dp, exp_seg[7*j +: 7], exp_dp[j]);
      end
    end
  endtask

  task automatic check_ready(input logic exp, input string name);
    checks++;
    if (value_ready !== exp) begin
      errors++;
      $display("[TB] FAIL %s: value_ready=%b, required %b", name, value_ready, exp);
    end
  endtask

  // Transfer at edge N, then watch ready and the old display through edge N+14.
  task automatic send_value(input logic [13:0] v, input logic [3:0] d,
                            input logic [27:0] old_seg, input logic [3:0] old_dp,
                            input string name);
    @(negedge clk);
    check_ready(1'b1, {name, "_ready_pre"});
    value = v; dp_en = d; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check_ready(i == 14, {name, "_ready_seq"});
      check_active(old_seg, old_dp, name);
      if (i < 14) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; value = '0; dp_en = '0; value_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_pins: an=%h seg=%h dp=%b, required F/7F/1", an, seg, dp);
    end
    check_ready(1'b0, "reset_ready_low");
    rst = 1'b0;
    @(negedge clk);
    check_ready(1'b1, "reset_ready_high");
    check_digits(SEG_ZERO, 4'hF, "reset_zero");
  endtask

  task automatic test_digits();
    send_value(14'd1234, 4'b0100, SEG_ZERO, 4'hF, "v1234");
    check_digits(SEG_1234, 4'b1011, "v1234");
    send_value(14'd7, 4'b0000, SEG_1234, 4'b1011, "v7");
    check_digits(SEG_7, 4'hF, "v7");
    send_value(14'd9999, 4'b0000, SEG_7, 4'hF, "v9999");
    check_digits(SEG_9999, 4'hF, "v9999");
  endtask

  task automatic test_overflow();
    send_value(14'd10000, 4'b1001, SEG_9999, 4'hF, "v10000");
    check_digits(SEG_DASH, 4'b0110, "v10000");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    check_ready(1'b1, "b2b_ready_pre");
    value = 14'd42; dp_en = 4'b0000; value_valid = 1'b1;
    @(negedge clk);
    value = 14'd5678;
    for (int i = 0; i < 15; i++) begin
      check_ready(i == 14, "b2b_ready_42");
      check_active(SEG_DASH, 4'b0110, "b2b_old");
      if (i < 14) @(negedge clk);
    end
    @(negedge clk);
    value_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check_ready(1'b0, "b2b_ready_5678");
      check_active(SEG_42, 4'hF, "b2b_42");
      @(negedge clk);
    end
    check_ready(1'b1, "b2b_ready_done");
    check_digits(SEG_5678, 4'hF, "b2b_5678");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    check_ready(1'b1, "abort_ready_pre");
    value = 14'd8888; dp_en = 4'b1111; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_ready(1'b0, "abort_ready_in_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_ready(1'b1, "abort_ready_after");
    check_digits(SEG_ZERO, 4'hF, "abort_zero");
  endtask

  initial begin
    test_reset();
    test_digits();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
